// File: rtl/fifo2_rr_arbiter_pkg.sv
// Shared definitions for the FIFO2 round-robin arbiter:
// lock FSM encodings and the index-width helper.
package fifo2_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // ceil(log2(n)), never less than 1 so a 1-bit index always exists
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo2_rr_arbiter_rr_prio_pick.sv
// Rotated priority encoder: first set request at or after start,
// wrapping at NREQ-1 (non-power-of-2 NREQ is legal).
module rr_prio_pick
    import fifo2_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [clog2(NREQ)-1:0]   start,
    output logic                     valid,
    output logic [clog2(NREQ)-1:0]   idx
);

    localparam int IW = clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    always_comb begin
        logic [IW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = start;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/fifo2_rr_arbiter.sv
// Round-robin merge of NREQ FIFO2 queues into one registered output.
// Define FIFO2_ARB_LOCK_EN to hold the grant for a whole packet.
module fifo2_rr_arbiter
    import fifo2_rr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int width = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic [NREQ-1:0]          REQ_EMPTY_N,
    input  logic [NREQ*width-1:0]    REQ_D_OUT,
    input  logic [NREQ-1:0]          REQ_LAST,
    output logic [NREQ-1:0]          REQ_DEQ,
    input  logic                     OUT_FULL_N,
    output logic                     OUT_ENQ,
    output logic [width-1:0]         OUT_D_IN,
    output logic                     OUT_LAST,
    output logic [clog2(NREQ)-1:0]   OUT_SRC
);

    localparam int IW = clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    logic             ovalid;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_nxt;
    logic             adv;
    logic             pop;
    logic             gv;
    logic [IW-1:0]    g;
    logic             pick_v;
    logic [IW-1:0]    pick_i;
    logic [width-1:0] g_data;
    logic             g_last;

    rr_prio_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (REQ_EMPTY_N),
        .start (ptr),
        .valid (pick_v),
        .idx   (pick_i)
    );

    assign adv     = !ovalid || OUT_FULL_N;
    assign OUT_ENQ = ovalid && OUT_FULL_N && !CLR;

`ifdef FIFO2_ARB_LOCK_EN
    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [IW-1:0] lock_id;
    logic [IW-1:0] lock_d;

    // While locked the encoder is bypassed; an empty owner means a bubble
    always_comb begin
        gv = pick_v;
        g  = pick_i;
        if (state_q == ARB_LOCKED) begin
            gv = REQ_EMPTY_N[lock_id];
            g  = lock_id;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_id;
        if (CLR) begin
            state_d = ARB_IDLE;
        end else if (pop) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (!g_last) begin
                        state_d = ARB_LOCKED;
                        lock_d  = g;
                    end
                end
                ARB_LOCKED: begin
                    if (g_last) begin
                        state_d = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            lock_id <= '0;
        end else begin
            state_q <= state_d;
            lock_id <= lock_d;
        end
    end
`else
    assign gv = pick_v;
    assign g  = pick_i;
`endif

    assign pop     = adv && gv && !CLR && !RST;
    assign ptr_nxt = (g == LAST_IDX) ? '0 : g + 1'b1;

    always_comb begin
        REQ_DEQ = '0;
        g_data  = '0;
        g_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g == IW'(i)) begin
                REQ_DEQ[i] = pop;
                g_data     = REQ_D_OUT[i*width +: width];
                g_last     = REQ_LAST[i];
            end
        end
    end

    // A pop keeps ovalid set even when the old beat drains this cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovalid   <= 1'b0;
            ptr      <= '0;
            OUT_D_IN <= '0;
            OUT_LAST <= 1'b0;
            OUT_SRC  <= '0;
        end else if (CLR) begin
            ovalid <= 1'b0;
            ptr    <= '0;
        end else if (pop) begin
            ovalid   <= 1'b1;
            ptr      <= ptr_nxt;
            OUT_D_IN <= g_data;
            OUT_LAST <= g_last;
            OUT_SRC  <= g;
        end else if (OUT_ENQ) begin
            ovalid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (!RST) begin
            if ((REQ_DEQ & ~REQ_EMPTY_N) != '0)
                $warning("fifo2_rr_arbiter: pop from empty queue");
            if (OUT_ENQ && !OUT_FULL_N)
                $warning("fifo2_rr_arbiter: enq while output full");
        end
    end
`endif

endmodule

// File: tb/tb_fifo2_rr_arbiter.sv
// Scoreboard bench for fifo2_rr_arbiter (NREQ=4 and NREQ=3 instances).
// Expected beats are queued by the stimulus; monitors pop and compare.
module tb_fifo2_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic [3:0]   req_en = '0;
    logic [127:0] req_d = '0;
    logic [3:0]   req_last = '0;
    logic [3:0]   req_deq;
    logic         full_n = 1'b1;
    logic         enq;
    logic [31:0]  od;
    logic         ol;
    logic [1:0]   osrc;

    logic [2:0]   en3 = '0;
    logic [95:0]  d3;
    logic [2:0]   last3;
    logic [2:0]   deq3;
    logic         full3;
    logic         enq3;
    logic [31:0]  od3;
    logic         ol3;
    logic [1:0]   src3;

    assign d3    = {32'h32, 32'h31, 32'h30};
    assign last3 = 3'b111;
    assign full3 = 1'b1;

    fifo2_rr_arbiter #(.NREQ(4), .width(32)) dut (
        .CLK(clk), .RST(rst), .CLR(clr),
        .REQ_EMPTY_N(req_en), .REQ_D_OUT(req_d),
        .REQ_LAST(req_last), .REQ_DEQ(req_deq),
        .OUT_FULL_N(full_n), .OUT_ENQ(enq),
        .OUT_D_IN(od), .OUT_LAST(ol), .OUT_SRC(osrc)
    );

    fifo2_rr_arbiter #(.NREQ(3), .width(32)) dut3 (
        .CLK(clk), .RST(rst), .CLR(clr),
        .REQ_EMPTY_N(en3), .REQ_D_OUT(d3),
        .REQ_LAST(last3), .REQ_DEQ(deq3),
        .OUT_FULL_N(full3), .OUT_ENQ(enq3),
        .OUT_D_IN(od3), .OUT_LAST(ol3), .OUT_SRC(src3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] qd [4][$];
    bit          ql [4][$];
    logic [31:0] ed [$];
    logic [1:0]  es [$];
    bit          el [$];
    logic [1:0]  e3 [$];

    logic [3:0]  deq_s;
    logic        enq_s;
    logic [31:0] od_s;
    logic [2:0]  deq3_s;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_en[i]         = 1'b0;
            req_d[i*32 +: 32] = 32'h0;
            req_last[i]       = 1'b0;
            if (qd[i].size() > 0) begin
                req_en[i]         = 1'b1;
                req_d[i*32 +: 32] = qd[i][0];
                req_last[i]       = ql[i][0];
            end
        end
    endtask

    task automatic push(input int i, input logic [31:0] d, input bit l);
        qd[i].push_back(d);
        ql[i].push_back(l);
    endtask

    task automatic expb(input logic [1:0] s, input logic [31:0] d,
                        input bit l);
        es.push_back(s);
        ed.push_back(d);
        el.push_back(l);
    endtask

    task automatic step();
        @(negedge clk);
        deq_s  = req_deq;
        enq_s  = enq;
        od_s   = od;
        deq3_s = deq3;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (deq_s[i]) begin
                if (qd[i].size() == 0) begin
                    chk("pop_empty", 32'd1, 32'd0);
                end else begin
                    void'(qd[i].pop_front());
                    void'(ql[i].pop_front());
                end
            end
        end
        drive();
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 4; k++) step();
        chk(nm, 32'(ed.size() + e3.size()), 32'd0);
        ed.delete(); es.delete(); el.delete(); e3.delete();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clr    = 1'b0;
        full_n = 1'b1;
        en3    = '0;
        for (int i = 0; i < 4; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        drive();
        #1;
        chk("rst_enq",  32'(enq),     32'd0);
        chk("rst_d",    od,           32'd0);
        chk("rst_last", 32'(ol),      32'd0);
        chk("rst_src",  32'(osrc),    32'd0);
        chk("rst_src3", 32'(src3),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && enq) begin
            if (ed.size() == 0) begin
                chk("beat_unexpected", od, 32'hFFFF_FFFF);
            end else begin
                chk("beat_src",  32'(osrc), 32'(es[0]));
                chk("beat_data", od,        ed[0]);
                chk("beat_last", 32'(ol),   32'(el[0]));
                void'(es.pop_front());
                void'(ed.pop_front());
                void'(el.pop_front());
            end
        end
        if (!rst && enq3) begin
            if (e3.size() == 0) begin
                chk("u3_unexpected", 32'(src3), 32'hFF);
            end else begin
                chk("u3_src",   32'(src3), 32'(e3[0]));
                chk("u3_data",  od3, 32'h30 + 32'(e3[0]));
                chk("u3_range", 32'(src3 < 2'd3), 32'd1);
                void'(e3.pop_front());
            end
        end
    end

    logic [3:0] exp2 [5];
    logic [3:0] exp3g [2];

    initial begin
        // 1: plain round robin 0,1,2,3,0 and first-beat latency
        do_reset();
        push(0, 32'hA0, 1'b1); push(1, 32'hA1, 1'b1);
        push(2, 32'hA2, 1'b1); push(3, 32'hA3, 1'b1);
        push(0, 32'hA4, 1'b1);
        drive();
        expb(0, 32'hA0, 1'b1); expb(1, 32'hA1, 1'b1);
        expb(2, 32'hA2, 1'b1); expb(3, 32'hA3, 1'b1);
        expb(0, 32'hA4, 1'b1);
        step();
        chk("t1_deq0", 32'(deq_s), 32'h1);
        chk("t1_enq0", 32'(enq_s), 32'd0);
        step();
        chk("t1_deq1", 32'(deq_s), 32'h2);
        chk("t1_enq1", 32'(enq_s), 32'd1);
        step();
        chk("t1_enq2", 32'(enq_s), 32'd1);
        drain("t1_drain");

        // 2: 3-beat packet on requester 1 with 0 and 2 busy
        do_reset();
        push(0, 32'hB0, 1'b1);
        drive();
        expb(0, 32'hB0, 1'b1);
        step();
        push(1, 32'hC0, 1'b0); push(1, 32'hC1, 1'b0);
        push(1, 32'hC2, 1'b1); push(2, 32'hD0, 1'b1);
        push(0, 32'hE0, 1'b1);
        drive();
`ifdef FIFO2_ARB_LOCK_EN
        expb(1, 32'hC0, 1'b0); expb(1, 32'hC1, 1'b0);
        expb(1, 32'hC2, 1'b1); expb(2, 32'hD0, 1'b1);
        expb(0, 32'hE0, 1'b1);
        exp2 = '{4'h2, 4'h2, 4'h2, 4'h4, 4'h1};
`else
        expb(1, 32'hC0, 1'b0); expb(2, 32'hD0, 1'b1);
        expb(0, 32'hE0, 1'b1); expb(1, 32'hC1, 1'b0);
        expb(1, 32'hC2, 1'b1);
        exp2 = '{4'h2, 4'h4, 4'h1, 4'h2, 4'h2};
`endif
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t2_deq%0d", k), 32'(deq_s), 32'(exp2[k]));
        end
        drain("t2_drain");

        // 3: owner queue runs dry mid-packet
        do_reset();
        push(3, 32'hF0, 1'b0);
        drive();
        expb(3, 32'hF0, 1'b0);
        step();
        chk("t3_first", 32'(deq_s), 32'h8);
        push(0, 32'h90, 1'b1); push(1, 32'h91, 1'b1);
        drive();
`ifdef FIFO2_ARB_LOCK_EN
        expb(3, 32'hF1, 1'b1); expb(0, 32'h90, 1'b1);
        expb(1, 32'h91, 1'b1);
        exp3g = '{4'h0, 4'h0};
`else
        expb(0, 32'h90, 1'b1); expb(1, 32'h91, 1'b1);
        expb(3, 32'hF1, 1'b1);
        exp3g = '{4'h1, 4'h2};
`endif
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("t3_gap%0d", k), 32'(deq_s), 32'(exp3g[k]));
        end
        push(3, 32'hF1, 1'b1);
        drive();
        step();
        chk("t3_resume", 32'(deq_s), 32'h8);
        drain("t3_drain");

        // 4: downstream full for 5 cycles
        do_reset();
        push(0, 32'h50, 1'b1); push(0, 32'h51, 1'b1);
        push(0, 32'h52, 1'b1);
        drive();
        expb(0, 32'h50, 1'b1); expb(0, 32'h51, 1'b1);
        expb(0, 32'h52, 1'b1);
        step();
        full_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_stall_deq", 32'(deq_s), 32'd0);
            chk("t4_hold", od_s, 32'h50);
            chk("t4_noenq", 32'(enq_s), 32'd0);
        end
        full_n = 1'b1;
        step();
        chk("t4_rel_enq", 32'(enq_s), 32'd1);
        chk("t4_refill", 32'(deq_s), 32'h1);
        drain("t4_drain");

        // 5: CLR while a packet is open and the output is occupied
        do_reset();
        push(2, 32'h70, 1'b0);
        drive();
        step();
        push(1, 32'h71, 1'b1); push(3, 32'h73, 1'b1);
        clr = 1'b1;
        drive();
        expb(1, 32'h71, 1'b1); expb(3, 32'h73, 1'b1);
        step();
        chk("t5_clr_enq", 32'(enq_s), 32'd0);
        chk("t5_clr_deq", 32'(deq_s), 32'd0);
        clr = 1'b0;
        step();
        chk("t5_enq_after", 32'(enq_s), 32'd0);
        chk("t5_first", 32'(deq_s), 32'h2);
        step();
        chk("t5_second", 32'(deq_s), 32'h8);
        drain("t5_drain");

        // 6: NREQ=3 wrap 2 -> 0
        do_reset();
        en3 = 3'b100;
        e3.push_back(2'd2); e3.push_back(2'd2);
        step();
        chk("t6_a0", 32'(deq3_s), 32'h4);
        step();
        chk("t6_a1", 32'(deq3_s), 32'h4);
        en3 = 3'b111;
        e3.push_back(2'd0); e3.push_back(2'd1);
        e3.push_back(2'd2); e3.push_back(2'd0);
        step();
        chk("t6_b0", 32'(deq3_s), 32'h1);
        step();
        chk("t6_b1", 32'(deq3_s), 32'h2);
        step();
        chk("t6_b2", 32'(deq3_s), 32'h4);
        step();
        chk("t6_b3", 32'(deq3_s), 32'h1);
        en3 = 3'b000;
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
